// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 Hz raster timing generator.
// Horizontal/vertical counters advance on pix_en; every output is a register
// decoded from the next-state counter values, so x/y and the sync/active
// levels never skew against each other.
// Optional feature macro: VGA_FRAME_COUNT_EN (adds the 8-bit frame counter;
// when undefined, frame_count is constant 0).
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FRONT  = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BACK   = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FRONT  = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BACK   = 33,
    parameter int SYNC_POL = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pix_en,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       frame_active,
    output logic       hsync,
    output logic       vsync,
    output logic       line_start,
    output logic       frame_start,
    output logic [7:0] frame_count
);

    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT_END  = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT_END  = 10'(V_ACTIVE);
    localparam logic [9:0] HS_FIRST   = 10'(H_ACTIVE + H_FRONT);
    localparam logic [9:0] HS_LAST    = 10'(H_ACTIVE + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST   = 10'(V_ACTIVE + V_FRONT);
    localparam logic [9:0] VS_LAST    = 10'(V_ACTIVE + V_FRONT + V_SYNC - 1);
    localparam logic       SYNC_ON    = (SYNC_POL != 0);
    localparam logic       SYNC_OFF   = ~SYNC_ON;

    logic [9:0] h_q, h_d;
    logic [9:0] v_q, v_d;
    logic       active_q, active_d;
    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;
    logic       line_start_q, line_start_d;
    logic       frame_start_q, frame_start_d;

    // Next-state counters and the decode of that next state. Levels hold
    // when pix_en is low; strobes fall after their single cycle.
    always_comb begin
        h_d           = h_q;
        v_d           = v_q;
        active_d      = active_q;
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        if (pix_en) begin
            if (h_q == H_LAST) begin
                h_d = 10'd0;
                v_d = (v_q == V_LAST) ? 10'd0 : v_q + 10'd1;
            end else begin
                h_d = h_q + 10'd1;
            end
            active_d      = (h_d < H_ACT_END) && (v_d < V_ACT_END);
            hsync_d       = ((h_d >= HS_FIRST) && (h_d <= HS_LAST)) ? SYNC_ON : SYNC_OFF;
            vsync_d       = ((v_d >= VS_FIRST) && (v_d <= VS_LAST)) ? SYNC_ON : SYNC_OFF;
            line_start_d  = (h_d == 10'd0);
            frame_start_d = (h_d == 10'd0) && (v_d == 10'd0);
        end
    end

    // Timing state; reset parks the beam on the last pixel of the frame so
    // the first enabled pixel lands on (0,0).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_q           <= H_LAST;
            v_q           <= V_LAST;
            active_q      <= 1'b0;
            hsync_q       <= SYNC_OFF;
            vsync_q       <= SYNC_OFF;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            h_q           <= h_d;
            v_q           <= v_d;
            active_q      <= active_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

`ifdef VGA_FRAME_COUNT_EN
    logic [7:0] fcnt_q, fcnt_d;

    // Frame counter steps on the same edge that raises frame_start.
    always_comb begin
        fcnt_d = fcnt_q;
        if (frame_start_d) begin
            fcnt_d = fcnt_q + 8'd1;
        end
    end

    // Frame counter register, wraps modulo 256.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fcnt_q <= 8'd0;
        end else begin
            fcnt_q <= fcnt_d;
        end
    end

    assign frame_count = fcnt_q;
`else
    assign frame_count = 8'd0;
`endif

    assign x            = h_q;
    assign y            = v_q;
    assign frame_active = active_q;
    assign hsync        = hsync_q;
    assign vsync        = vsync_q;
    assign line_start   = line_start_q;
    assign frame_start  = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a full-size 640x480 instance (active-low syncs)
// and a shrunken instance with SYNC_POL=1 so whole frames and 256-frame
// wraps fit in a short run. Expected outputs come from a model that maps the
// number of enabled pixels since reset to a linear raster position.
module tb_vga_timing_gen;

  localparam int EW = 33;

  // small-instance geometry: 13 x 9, hsync x=8..10, vsync y=5..6
  localparam int S_HA = 6, S_HF = 2, S_HS = 3, S_HB = 2;
  localparam int S_VA = 4, S_VF = 1, S_VS = 2, S_VB = 2;
  localparam int S_HT = S_HA + S_HF + S_HS + S_HB;
  localparam int S_VT = S_VA + S_VF + S_VS + S_VB;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n_b, pix_en_b;
  logic [9:0] x_b, y_b;
  logic       fa_b, hs_b, vs_b, ls_b, fs_b;
  logic [7:0] fc_b;

  logic       rst_n_s, pix_en_s;
  logic [9:0] x_s, y_s;
  logic       fa_s, hs_s, vs_s, ls_s, fs_s;
  logic [7:0] fc_s;

  vga_timing_gen dut_big (
    .clk(clk), .rst_n(rst_n_b), .pix_en(pix_en_b),
    .x(x_b), .y(y_b), .frame_active(fa_b), .hsync(hs_b), .vsync(vs_b),
    .line_start(ls_b), .frame_start(fs_b), .frame_count(fc_b)
  );

  vga_timing_gen #(
    .H_ACTIVE(S_HA), .H_FRONT(S_HF), .H_SYNC(S_HS), .H_BACK(S_HB),
    .V_ACTIVE(S_VA), .V_FRONT(S_VF), .V_SYNC(S_VS), .V_BACK(S_VB),
    .SYNC_POL(1)
  ) dut_small (
    .clk(clk), .rst_n(rst_n_s), .pix_en(pix_en_s),
    .x(x_s), .y(y_s), .frame_active(fa_s), .hsync(hs_s), .vsync(vs_s),
    .line_start(ls_s), .frame_start(fs_s), .frame_count(fc_s)
  );

  int checks = 0;
  int failures = 0;

  // model state: enabled pixels since reset, and whether the last edge was enabled
  int n_b = 0, n_s = 0;
  bit en_b = 0, en_s = 0;

  logic [EW-1:0] got, exp_v;

`ifdef VGA_FRAME_COUNT_EN
  localparam bit FC_EN = 1'b1;
`else
  localparam bit FC_EN = 1'b0;
`endif

  // Raster position = (n - 1) mod frame_size, with n=0 meaning the last pixel.
  function automatic logic [EW-1:0] model(int n, bit edge_en, int ha, int hf, int hsw, int hb,
                                          int va, int vf, int vsw, int vb, bit pol);
    int ht, vt, f, pos, px, py, fc;
    bit fa, hsy, vsy, ls, fs;
    ht  = ha + hf + hsw + hb;
    vt  = va + vf + vsw + vb;
    f   = ht * vt;
    pos = (n == 0) ? f - 1 : (n - 1) % f;
    px  = pos % ht;
    py  = pos / ht;
    fa  = (px < ha) && (py < va);
    hsy = (px >= ha + hf && px < ha + hf + hsw) ? pol : !pol;
    vsy = (py >= va + vf && py < va + vf + vsw) ? pol : !pol;
    ls  = edge_en && (n > 0) && (px == 0);
    fs  = ls && (py == 0);
    fc  = (FC_EN && n > 0) ? (((n - 1) / f) + 1) % 256 : 0;
    return {10'(px), 10'(py), fa, hsy, vsy, ls, fs, 8'(fc)};
  endfunction

  function automatic logic [EW-1:0] exp_big();
    return model(n_b, en_b, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0);
  endfunction

  function automatic logic [EW-1:0] exp_small();
    return model(n_s, en_s, S_HA, S_HF, S_HS, S_HB, S_VA, S_VF, S_VS, S_VB, 1'b1);
  endfunction

  // drive one clk of the full-size instance; sample 1 time unit after the edge
  task automatic drive_big(input bit en);
    pix_en_b = en;
    @(posedge clk);
    #1;
    if (en) n_b++;
    en_b = en;
    got = {x_b, y_b, fa_b, hs_b, vs_b, ls_b, fs_b, fc_b};
  endtask

  task automatic drive_small(input bit en);
    pix_en_s = en;
    @(posedge clk);
    #1;
    if (en) n_s++;
    en_s = en;
    got = {x_s, y_s, fa_s, hs_s, vs_s, ls_s, fs_s, fc_s};
  endtask

  task automatic test_reset();
    logic [EW-1:0] rst_exp;
    rst_exp = {10'd799, 10'd524, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0};
    drive_big(1'b0);
    checks++;
    if (got !== rst_exp) begin
      failures++;
      $display("FAIL reset_initial got=%h exp=%h", got, rst_exp);
    end
    // run to x=300 on line 0 (301 enabled pixels)
    for (int i = 0; i < 301; i++) drive_big(1'b1);
    checks++;
    if (x_b !== 10'd300 || y_b !== 10'd0) begin
      failures++;
      $display("FAIL reset_pre_pos got=%0d,%0d exp=300,0", x_b, y_b);
    end
    // asynchronous assertion mid-line, checked before any clock edge
    rst_n_b = 1'b0;
    #1;
    got = {x_b, y_b, fa_b, hs_b, vs_b, ls_b, fs_b, fc_b};
    checks++;
    if (got !== rst_exp) begin
      failures++;
      $display("FAIL reset_async got=%h exp=%h", got, rst_exp);
    end
    n_b = 0;
    en_b = 0;
    @(posedge clk);
    #2;
    rst_n_b = 1'b1;
    drive_big(1'b1);
    exp_v = {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, FC_EN ? 8'd1 : 8'd0};
    checks++;
    if (got !== exp_v) begin
      failures++;
      $display("FAIL reset_first_pixel got=%h exp=%h", got, exp_v);
    end
  endtask

  task automatic test_horizontal();
    int hs_low = 0, last_ls = -1, ls_bad = 0;
    for (int i = 0; i < 1700; i++) begin
      drive_big(1'b1);
      exp_v = exp_big();
      checks++;
      if (got !== exp_v) begin
        failures++;
        $display("FAIL horiz_cycle i=%0d got=%h exp=%h", i, got, exp_v);
      end
      if (y_b == 10'd0 && hs_b == 1'b0) hs_low++;
      if (ls_b) begin
        if (last_ls >= 0 && i - last_ls != 800) ls_bad++;
        last_ls = i;
      end
    end
    checks++;
    if (hs_low != 96) begin
      failures++;
      $display("FAIL horiz_hsync_width got=%0d exp=96", hs_low);
    end
    checks++;
    if (ls_bad != 0 || last_ls < 0) begin
      failures++;
      $display("FAIL horiz_line_period bad=%0d last=%0d exp=0 bad", ls_bad, last_ls);
    end
  endtask

  task automatic test_random_enable();
    for (int i = 0; i < 3000; i++) begin
      drive_big(1'($urandom_range(0, 1)));
      exp_v = exp_big();
      checks++;
      if (got !== exp_v) begin
        failures++;
        $display("FAIL rand_en i=%0d got=%h exp=%h", i, got, exp_v);
      end
    end
  endtask

  task automatic test_enable_stall();
    int last_ls = -1, period = 0, wide = 0;
    bit prev_ls = 0;
    rst_n_b = 1'b0;
    #1;
    n_b = 0;
    en_b = 0;
    @(posedge clk);
    #2;
    rst_n_b = 1'b1;
    for (int i = 0; i < 1700; i++) begin
      drive_big(i % 2 == 0);
      exp_v = exp_big();
      checks++;
      if (got !== exp_v) begin
        failures++;
        $display("FAIL stall_cycle i=%0d got=%h exp=%h", i, got, exp_v);
      end
      if (ls_b && prev_ls) wide++;
      if (ls_b) begin
        if (last_ls >= 0) period = i - last_ls;
        last_ls = i;
      end
      prev_ls = ls_b;
    end
    checks++;
    if (period != 1600 || wide != 0) begin
      failures++;
      $display("FAIL stall_line_period got=%0d wide=%0d exp=1600 wide=0", period, wide);
    end
  endtask

  task automatic test_polarity_reset();
    logic [EW-1:0] rst_exp;
    rst_exp = {10'(S_HT - 1), 10'(S_VT - 1), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
    drive_small(1'b0);
    checks++;
    if (got !== rst_exp) begin
      failures++;
      $display("FAIL pol_reset got=%h exp=%h", got, rst_exp);
    end
    rst_n_s = 1'b1;
  endtask

  task automatic test_vertical_wrap();
    int vs_hi = 0, hs_hi = 0, last_fs = -1, fs_bad = 0, fs_seen = 0;
    for (int i = 0; i < 3 * S_HT * S_VT + 5; i++) begin
      drive_small(1'b1);
      exp_v = exp_small();
      checks++;
      if (got !== exp_v) begin
        failures++;
        $display("FAIL vert_cycle i=%0d got=%h exp=%h", i, got, exp_v);
      end
      if (i < S_HT * S_VT) begin
        if (vs_s) vs_hi++;
        if (hs_s && y_s == 10'd0) hs_hi++;
      end
      if (fs_s) begin
        fs_seen++;
        if (!ls_s) fs_bad++;
        if (last_fs >= 0 && i - last_fs != S_HT * S_VT) fs_bad++;
        last_fs = i;
      end
    end
    checks++;
    if (vs_hi != 2 * S_HT) begin
      failures++;
      $display("FAIL vert_vsync_width got=%0d exp=%0d", vs_hi, 2 * S_HT);
    end
    checks++;
    if (hs_hi != S_HS) begin
      failures++;
      $display("FAIL pol_hsync_width got=%0d exp=%0d", hs_hi, S_HS);
    end
    checks++;
    if (fs_bad != 0 || fs_seen != 4) begin
      failures++;
      $display("FAIL vert_frame_start bad=%0d seen=%0d exp=0,4", fs_bad, fs_seen);
    end
  endtask

  task automatic test_frame_wrap();
    int target;
    int guard = 0;
    bit saw_wrap = 0;
    logic [7:0] prev_fc;
    target = 258 * S_HT * S_VT + 3;
    prev_fc = fc_s;
    while (n_s < target && guard < 60000) begin
      guard++;
      drive_small($urandom_range(0, 3) != 0);
      exp_v = exp_small();
      checks++;
      if (got !== exp_v) begin
        failures++;
        $display("FAIL fc_cycle n=%0d got=%h exp=%h", n_s, got, exp_v);
      end
      if (prev_fc == 8'd255 && fc_s == 8'd0) saw_wrap = 1;
      prev_fc = fc_s;
    end
    checks++;
    if (n_s < target) begin
      failures++;
      $display("FAIL fc_budget got=%0d exp=%0d", n_s, target);
    end
    checks++;
    if (saw_wrap != FC_EN) begin
      failures++;
      $display("FAIL fc_wrap got=%0d exp=%0d", saw_wrap, FC_EN);
    end
  endtask

  initial begin
    rst_n_b  = 1'b0;
    rst_n_s  = 1'b0;
    pix_en_b = 1'b0;
    pix_en_s = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n_b = 1'b1;
    test_reset();
    test_horizontal();
    test_random_enable();
    test_enable_stall();
    test_polarity_reset();
    test_vertical_wrap();
    test_frame_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Generates raster timing for a 640x480 @ 60 Hz VGA display and feeds the pixel-colour stage with its beam coordinates. The block holds horizontal and vertical counters that advance on a pixel-clock enable. From the counters it produces `x`, `y`, `frame_active`, `hsync`, `vsync` and per-line and per-frame strobes. It sits directly upstream of the colour generator, which consumes `x`, `y` and `frame_active`.

## Interface
- `H_ACTIVE`, 640, visible pixels per line
- `H_FRONT`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, hsync width (pixels)
- `H_BACK`, 48, horizontal back porch (pixels)
- `V_ACTIVE`, 480, visible lines per frame
- `V_FRONT`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vsync width (lines)
- `V_BACK`, 33, vertical back porch (lines)
- `SYNC_POL`, 0, asserted level of `hsync`/`vsync` (0 = active-low)

Ports:
- `clk` input 1: system clock; the only clock
- `rst_n` input 1: reset, asynchronous, active-low
- `pix_en` input 1: pixel-clock enable; the counters advance one pixel per `clk` edge with `pix_en`=1
- `x` output 10: horizontal count, 0..H_TOTAL-1
- `y` output 10: vertical count, 0..V_TOTAL-1
- `frame_active` output 1: high when x<H_ACTIVE and y<V_ACTIVE
- `hsync` output 1: horizontal sync, level per SYNC_POL
- `vsync` output 1: vertical sync, level per SYNC_POL
- `line_start` output 1: one-`clk` pulse on entry to x=0
- `frame_start` output 1: one-`clk` pulse on entry to (0,0)
- `frame_count` output 8: frames started, modulo 256

## Operation
- H_TOTAL = H_ACTIVE+H_FRONT+H_SYNC+H_BACK (800). V_TOTAL = V_ACTIVE+V_FRONT+V_SYNC+V_BACK (525). Both totals must fit in 10 bits.
- Counter advance on `pix_en`=1: if h=H_TOTAL-1, h wraps to 0 and v advances. v wraps to 0 from V_TOTAL-1. Otherwise h increments.
- With `pix_en`=0, all state and level outputs hold.
- All outputs are registers and reflect the same counter state, so there is zero skew between `x`/`y` and `frame_active`/`hsync`/`vsync`. Decode is computed from next-state values.
- `hsync` is asserted for h in [H_ACTIVE+H_FRONT, H_ACTIVE+H_FRONT+H_SYNC-1], i.e. 656..751.
- `vsync` is asserted for v in [V_ACTIVE+V_FRONT, V_ACTIVE+V_FRONT+V_SYNC-1], i.e. 490..491. It is asserted for whole lines, with its edges coincident with h=0.
- `line_start` is high for exactly the first `clk` cycle in which h=0, even when `pix_en` holds the state for several cycles.
- `frame_start` is high for exactly the first `clk` cycle in which h=0 and v=0. It always coincides with `line_start`.
- `frame_count` increments in the same cycle `frame_start` rises. It wraps from 255 to 0.

## Timing
- Reset (async, while `rst_n`=0):
  - h = H_TOTAL-1, v = V_TOTAL-1, so x=799 and y=524
  - `frame_active`=0; `hsync`=`vsync`=!SYNC_POL
  - `line_start`=`frame_start`=0; `frame_count`=0
- First `pix_en` edge after reset: the state moves to (0,0), `frame_active`=1, `line_start`=`frame_start`=1, `frame_count`=1.
- Latency: outputs change on the same `clk` edge that samples `pix_en`=1, with zero additional cycles.
- Reset asserted mid-frame: all outputs return to the reset values immediately, with no partial-line completion.
- `pix_en` tied high: one line is 800 `clk` cycles and one frame is 420000 `clk` cycles.
- Downstream stages that register colour add their own delay to `hsync`/`vsync`. This block does not compensate for it.

## Configuration
- `VGA_FRAME_COUNT_EN` defined: the 8-bit `frame_count` register is present and behaves as described above.
- `VGA_FRAME_COUNT_EN` undefined: the register is omitted and `frame_count` is constant 0. All other behaviour is unchanged.

## Test plan
- Reset check: assert `rst_n`=0 mid-line at x=300 -> immediately x=799, y=524, `frame_active`=0, `hsync`=`vsync`=1, `frame_count`=0. Release reset with one `pix_en` -> x=0, y=0, `frame_start`=1, `frame_count`=1.
- Horizontal timing: `pix_en`=1 constantly -> `hsync` low for x=656..751 (96 cycles), line period 800 cycles, `frame_active` high for x=0..639 on lines 0..479.
- Vertical timing and wrap: run a full frame -> `vsync` low for exactly 1600 cycles (y=490..491). After y=524,x=799 the next state is (0,0) with one-cycle `frame_start`.
- Enable stall: `pix_en` high every 2nd `clk` -> the state holds 2 cycles per pixel, `line_start` is 1 cycle wide, and the line period is 1600 cycles.
- Counter wrap: run 256 frames -> `frame_count` reads 255 then 0. Build without `VGA_FRAME_COUNT_EN` -> `frame_count`=0 throughout.
- Polarity: elaborate with SYNC_POL=1 -> syncs are idle 0 at reset and high for x=656..751 and y=490..491.
